multibyte_add_seq: RTL and testbench
====================================

Name: multibyte_add_seq

Overview:
- Sequencer directly upstream of the 8-bit adder stage (inputs a, b, cin; outputs s, cout).
- Accepts wide operands one byte per transfer, least-significant byte first, and drives each byte pair plus the chained carry into the adder.
- Registers the adder's sum byte and carry into a one-deep output stage with valid/ready handshake.
- Together with the adder, forms an N-byte ripple-by-byte adder.

Parameters:
- NBYTES, 4: bytes per operand word; legal values are 2 to 16.
- IDXW, $clog2(NBYTES): width of the byte index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte pair on in_a/in_b/in_cin0 is valid.
- in_ready  output  1  sequencer accepts a byte this cycle.
- in_a  input  8  operand A byte.
- in_b  input  8  operand B byte.
- in_cin0  input  1  initial carry-in; sampled only on byte 0 of a word.
- add_a  output  8  to adder input a.
- add_b  output  8  to adder input b.
- add_cin  output  1  to adder cin.
- add_s  input  8  from adder sum.
- add_cout  input  1  from adder carry-out, a true 9th sum bit.
- out_valid  output  1  result byte available.
- out_ready  input  1  downstream accepts result byte.
- out_s  output  8  registered sum byte.
- out_idx  output  IDXW  byte index of out_s (0 = LSB).
- out_last  output  1  out_s is byte NBYTES-1.
- out_cout  output  1  final carry of the word; meaningful only when out_last=1, else 0.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: out_valid=0, out_s=0, out_idx=0, out_last=0, out_cout=0, byte counter=0, carry register=0, state=S_FIRST.
- Ready rule: in_ready = !out_valid || out_ready. This is combinational; in_ready is also 0 while reset=1.
- Accept: acc = in_valid && in_ready.
- Adder drive is combinational:
  - add_a = in_a and add_b = in_b.
  - add_cin = in_cin0 in S_FIRST, else carry_q.
  - Inputs are driven regardless of acc; the adder output is used only on acc.
- State machine:
  - S_FIRST: waiting for byte 0. On acc: capture the result. If NBYTES>1, set carry_q=add_cout, cnt=1, go to S_CHAIN.
  - S_CHAIN: on acc: capture the result and set carry_q=add_cout.
    - If cnt==NBYTES-1: carry_q=0, cnt=0, go to S_FIRST.
    - Else cnt=cnt+1.
- Capture on acc, registered and visible the next cycle:
  - out_s=add_s, out_idx=cnt, out_valid=1.
  - out_last=(cnt==NBYTES-1).
  - out_cout = add_cout if last, else 0.
- Output drain: if out_valid && out_ready && !acc, then out_valid=0. Other out_* fields hold their values.
- Simultaneous drain and accept: the output register is overwritten with the new byte and out_valid stays 1. This gives full throughput of one byte per cycle.
- Latency: one cycle from acc to out_valid.
- Stability: out_* fields hold stable while out_valid && !out_ready.
- Arithmetic: each byte computes {cout,s} = in_a + in_b + cin as a 9-bit result. Word result = concatenation of bytes with out_cout as bit 8*NBYTES.
- Wrap-around: cnt returns to 0 after byte NBYTES-1. There is no gap cycle between words.
- Reset mid-word: any partial word is discarded. A pending output byte is dropped (out_valid=0). The next accepted byte is treated as byte 0.
- in_valid while in_ready=0: no state change; upstream must hold its data.

Decomposition:
- Package multibyte_add_pkg holds:
  - typedef enum logic {S_FIRST, S_CHAIN} seq_state_t;
  - localparam int NBYTES_DEFAULT = 4.
- No sub-module inside. The 8-bit adder stays a separate instance wired through the add_* ports at the parent level.
- The bench instantiates both.

Test Plan:
1. NBYTES=4, out_ready=1, bytes (FF,01),(00,00),(00,00),(00,00), cin0=0 -> out_s 00,01,00,00; out_idx 0..3; out_last on idx 3 only; out_cout=0.
2. Bytes FF+00 in all 4 positions, cin0=1 -> out_s 00,00,00,00; out_cout=1 on idx 3; carry chains through every byte.
3. Back-to-back words with in_valid held high, out_ready=1 -> 8 outputs in 8 consecutive cycles; carry_q starts at cin0 of word 2, with no leakage from word 1's final carry.
4. Backpressure: out_ready=0 after byte 1 -> in_ready=0 next cycle; out_s/out_idx stable for 5 cycles; releasing out_ready resumes with idx 2 and the correct carry.
5. Reset asserted for 1 cycle after byte 2 of a word (carry_q=1) -> all outputs return to reset values; next word (12,34),(00,00),.. yields out_s 46,00,.. with no stale carry.
6. NBYTES=2, bytes (80,80),(7F,00) -> out_s 00,80; out_cout=0; out_last on idx 1.

Source files
------------

// File: rtl/multibyte_add_pkg.sv
// Shared types and defaults for the byte-serial multi-byte adder sequencer.
package multibyte_add_pkg;

    // S_FIRST waits for byte 0 of a word; S_CHAIN handles bytes 1..NBYTES-1.
    typedef enum logic {
        S_FIRST = 1'b0,
        S_CHAIN = 1'b1
    } seq_state_t;

    localparam int NBYTES_DEFAULT = 4;

endpackage : multibyte_add_pkg

// File: rtl/multibyte_add_seq_adder8.sv
// Plain 8-bit adder stage that sits next to the sequencer; cout is the 9th sum bit.
module multibyte_add_seq_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    // Full 9-bit sum of the two bytes plus carry-in.
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    end

endmodule : multibyte_add_seq_adder8

// File: rtl/multibyte_add_seq.sv
// Byte-serial sequencer feeding an external 8-bit adder. Operand bytes arrive
// LSB first; the carry is chained between bytes and each sum byte is captured
// into a one-deep output register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. The sender holds its data stable while valid=1 and ready=0. in_ready is
// combinational (!out_valid || out_ready), so a drain and a new capture can
// occur in the same cycle, giving one byte per cycle of throughput.
module multibyte_add_seq
    import multibyte_add_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT,
    parameter int IDXW   = $clog2(NBYTES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_a,
    input  logic [7:0]      in_b,
    input  logic            in_cin0,
    output logic [7:0]      add_a,
    output logic [7:0]      add_b,
    output logic            add_cin,
    input  logic [7:0]      add_s,
    input  logic            add_cout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_s,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            out_cout
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    seq_state_t      state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_s_q, out_s_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic            out_last_q, out_last_d;
    logic            out_cout_q, out_cout_d;

    logic            acc;
    logic            is_last;

    assign is_last = (cnt_q == LAST_IDX);

    // State and output registers; reset discards any partial word and pending byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FIRST;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_s_q     <= 8'd0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
        end
    end

    // Next state: advance the byte counter and carry chain, capture/drain the output byte.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_s_d     = out_s_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;

        if (acc) begin
            out_valid_d = 1'b1;
            out_s_d     = add_s;
            out_idx_d   = cnt_q;
            out_last_d  = is_last;
            out_cout_d  = is_last ? add_cout : 1'b0;

            unique case (state_q)
                S_FIRST: begin
                    carry_d = add_cout;
                    cnt_d   = IDXW'(1);
                    state_d = S_CHAIN;
                end
                S_CHAIN: begin
                    if (is_last) begin
                        carry_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_FIRST;
                    end else begin
                        carry_d = add_cout;
                        cnt_d   = cnt_q + IDXW'(1);
                    end
                end
                default: begin
                    state_d = S_FIRST;
                end
            endcase
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Outputs: ready rule, accept strobe, adder drive and registered result fields.
    always_comb begin
        in_ready  = !reset && (!out_valid_q || out_ready);
        acc       = in_valid && in_ready;
        add_a     = in_a;
        add_b     = in_b;
        add_cin   = (state_q == S_FIRST) ? in_cin0 : carry_q;
        out_valid = out_valid_q;
        out_s     = out_s_q;
        out_idx   = out_idx_q;
        out_last  = out_last_q;
        out_cout  = out_cout_q;
    end

endmodule : multibyte_add_seq

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq paired with its 8-bit adder. Expected bytes come
// from whole-word arithmetic on the operands; results are matched in order.
module tb_multibyte_add_seq;

    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    // NBYTES=4 instance
    logic       in_valid, in_ready, in_cin0;
    logic [7:0] in_a, in_b;
    logic [7:0] add_a, add_b, add_s;
    logic       add_cin, add_cout;
    logic       out_valid, out_ready, out_last, out_cout;
    logic [7:0] out_s;
    logic [1:0] out_idx;
    // NBYTES=2 instance
    logic       in_valid_2, in_ready_2, in_cin0_2;
    logic [7:0] in_a_2, in_b_2;
    logic [7:0] add_a_2, add_b_2, add_s_2;
    logic       add_cin_2, add_cout_2;
    logic       out_valid_2, out_ready_2, out_last_2, out_cout_2;
    logic [7:0] out_s_2;
    logic [0:0] out_idx_2;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin0(in_cin0),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_idx(out_idx), .out_last(out_last), .out_cout(out_cout)
    );

    multibyte_add_seq_adder8 u_add (
        .a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_cout)
    );

    multibyte_add_seq #(.NBYTES(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_2), .in_ready(in_ready_2),
        .in_a(in_a_2), .in_b(in_b_2), .in_cin0(in_cin0_2),
        .add_a(add_a_2), .add_b(add_b_2), .add_cin(add_cin_2),
        .add_s(add_s_2), .add_cout(add_cout_2),
        .out_valid(out_valid_2), .out_ready(out_ready_2),
        .out_s(out_s_2), .out_idx(out_idx_2), .out_last(out_last_2), .out_cout(out_cout_2)
    );

    multibyte_add_seq_adder8 u_add_2 (
        .a(add_a_2), .b(add_b_2), .cin(add_cin_2), .s(add_s_2), .cout(add_cout_2)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [11:0] exp_q[$];      // {cout, last, idx[1:0], s[7:0]}
    int          pop_times[$];
    logic        hold_v = 1'b0;
    logic [11:0] hold_val = '0;
    logic        last_in_ready = 1'b0;
    logic        rand_bp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: add the whole words at once, then slice into expected output bytes.
    task automatic push_word(input logic [31:0] a, input logic [31:0] b, input logic cin,
                             input int nsent);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 33'(cin);
        for (int i = 0; i < nsent; i++) begin
            exp_q.push_back({(i == NB - 1) ? sum[32] : 1'b0, (i == NB - 1), 2'(i), sum[8*i +: 8]});
        end
    endtask

    // One clock: monitor at the falling edge, then return 1 time unit after the rising edge.
    task automatic tick();
        logic [11:0] obs;
        @(negedge clk);
        last_in_ready = in_ready;
        obs = {out_cout, out_last, out_idx, out_s};
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("hold_stable", {19'd0, out_valid, obs}, {19'd0, 1'b1, hold_val});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_out observed %0h expected none", obs);
                end else begin
                    check("out_byte", 32'(obs), 32'(exp_q.pop_front()));
                end
                pop_times.push_back(cyc);
            end
            hold_v   = out_valid && !out_ready;
            hold_val = obs;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin0  = c;
        do begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end while (!last_in_ready && n < 100);
        if (!last_in_ready) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed stalled expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] b, input logic cin);
        push_word(a, b, cin, NB);
        for (int i = 0; i < NB; i++) begin
            send_byte(a[8*i +: 8], b[8*i +: 8], (i == 0) ? cin : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [16:0] s2;
        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin0 = 1'b0; out_ready = 1'b1;
        in_valid_2 = 1'b0; in_a_2 = '0; in_b_2 = '0; in_cin0_2 = 1'b0; out_ready_2 = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_s", 32'(out_s), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid_2", 32'(out_valid_2), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // 1: carry from byte 0 into byte 1
        send_word(32'h0000_00FF, 32'h0000_0001, 1'b0);
        drain();

        // 2: cin0 ripples through every byte to the final carry
        send_word(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drain();

        // 3: back-to-back words, no carry leakage between words
        pop_times.delete();
        send_word(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send_word(32'h0000_0000, 32'h0000_0000, 1'b0);
        drain();
        check("tput_count", 32'(pop_times.size()), 32'd8);
        check("tput_span", 32'(pop_times[7] - pop_times[0]), 32'd7);

        // 4: backpressure after byte 1, then resume with the chained carry
        push_word(32'h0010_FFFF, 32'h0020_0001, 1'b0, NB);
        send_byte(8'hFF, 8'h01, 1'b0);
        send_byte(8'hFF, 8'h00, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; in_cin0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_idx", 32'(out_idx), 32'd1);
        end
        out_ready = 1'b1;
        send_byte(8'h10, 8'h20, 1'b1);
        send_byte(8'h00, 8'h00, 1'b0);
        drain();

        // 5: reset mid-word with carry pending and an undrained output byte
        push_word(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 2);
        send_byte(8'hFF, 8'h01, 1'b0);
        send_byte(8'hFF, 8'h00, 1'b0);
        send_byte(8'hFF, 8'h00, 1'b0);
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_s", 32'(out_s), 32'd0);
        check("mid_rst_out_idx", 32'(out_idx), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        check("mid_rst_out_cout", 32'(out_cout), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        send_word(32'h0000_0012, 32'h0000_0034, 1'b0);
        drain();

        // 6: two-byte instance
        s2 = {1'b0, 16'h7F80} + {1'b0, 16'h0080};
        in_valid_2 = 1'b1; in_a_2 = 8'h80; in_b_2 = 8'h80; in_cin0_2 = 1'b0;
        tick();
        check("nb2_b0_valid", 32'(out_valid_2), 32'd1);
        check("nb2_b0_s", 32'(out_s_2), 32'(s2[7:0]));
        check("nb2_b0_idx", 32'(out_idx_2), 32'd0);
        check("nb2_b0_last", 32'(out_last_2), 32'd0);
        check("nb2_b0_cout", 32'(out_cout_2), 32'd0);
        in_a_2 = 8'h7F; in_b_2 = 8'h00; in_cin0_2 = 1'b1;
        tick();
        check("nb2_b1_s", 32'(out_s_2), 32'(s2[15:8]));
        check("nb2_b1_idx", 32'(out_idx_2), 32'd1);
        check("nb2_b1_last", 32'(out_last_2), 32'd1);
        check("nb2_b1_cout", 32'(out_cout_2), 32'(s2[16]));
        in_valid_2 = 1'b0;
        tick();
        check("nb2_drained", 32'(out_valid_2), 32'd0);

        // Random words with random output backpressure
        rand_bp = 1'b1;
        for (int w = 0; w < 25; w++) begin
            send_word($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_multibyte_add_seq
